// File: rtl/axi_traffic_generator_if.sv
// AXI4 master-side bundle (m_* socket naming) shared by the traffic generator and its memory model.
interface axi_traffic_generator_if #(
   parameter int AXI_AWIDTH = 64,
   parameter int AXI_DWIDTH = 512
);
   logic [3:0]              m_arid;
   logic [AXI_AWIDTH-1:0]   m_araddr;
   logic                    m_arvalid;
   logic [7:0]              m_arlen;
   logic [2:0]              m_arsize;
   logic [1:0]              m_arburst;
   logic                    m_arready;

   logic [3:0]              m_rid;
   logic [AXI_DWIDTH-1:0]   m_rdata;
   logic                    m_rvalid;
   logic                    m_rlast;
   logic [1:0]              m_rresp;
   logic                    m_rready;

   logic [3:0]              m_awid;
   logic [AXI_AWIDTH-1:0]   m_awaddr;
   logic                    m_awvalid;
   logic [7:0]              m_awlen;
   logic [2:0]              m_awsize;
   logic [1:0]              m_awburst;
   logic                    m_awready;

   logic [3:0]              m_wid;
   logic [AXI_DWIDTH-1:0]   m_wdata;
   logic                    m_wvalid;
   logic                    m_wlast;
   logic [AXI_DWIDTH/8-1:0] m_wstrb;
   logic                    m_wready;

   logic [3:0]              m_bid;
   logic [1:0]              m_bresp;
   logic                    m_bvalid;
   logic                    m_bready;

   modport master (
      output m_arid, m_araddr, m_arvalid, m_arlen, m_arsize, m_arburst,
      input  m_arready,
      input  m_rid, m_rdata, m_rvalid, m_rlast, m_rresp,
      output m_rready,
      output m_awid, m_awaddr, m_awvalid, m_awlen, m_awsize, m_awburst,
      input  m_awready,
      output m_wid, m_wdata, m_wvalid, m_wlast, m_wstrb,
      input  m_wready,
      input  m_bid, m_bresp, m_bvalid,
      output m_bready
   );

   modport slave (
      input  m_arid, m_araddr, m_arvalid, m_arlen, m_arsize, m_arburst,
      output m_arready,
      output m_rid, m_rdata, m_rvalid, m_rlast, m_rresp,
      input  m_rready,
      input  m_awid, m_awaddr, m_awvalid, m_awlen, m_awsize, m_awburst,
      output m_awready,
      input  m_wid, m_wdata, m_wvalid, m_wlast, m_wstrb,
      output m_wready,
      output m_bid, m_bresp, m_bvalid,
      input  m_bready
   );
endinterface

// File: rtl/axi_traffic_generator.sv
// Programmable AXI4 write/read-back traffic generator with in-line pattern check.
// One transaction outstanding at a time; bursts split at 4KB boundaries.
module axi_traffic_generator #(
   parameter int AXI_AWIDTH        = 64,
   parameter int AXI_DWIDTH        = 512,
   parameter int AXI_MAX_BURST_LEN = 16,
   parameter int WORD_WIDTH        = 64,
   parameter int AXI_ID            = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   axi_traffic_generator_if.master   m,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [AXI_AWIDTH-1:0]     base_addr,
   input  logic [31:0]               num_beats,
   input  logic [8:0]                burst_len,
   input  logic [63:0]               seed,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               err_count,
   output logic [31:0]               first_err_beat,
   output logic [31:0]               beats_written,
   output logic [31:0]               beats_read
);
   localparam int BYTES = AXI_DWIDTH / 8;
   localparam int WPB   = AXI_DWIDTH / WORD_WIDTH;
   localparam int SIZE  = $clog2(BYTES);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] W_ADDR = 3'd1;
   localparam logic [2:0] W_DATA = 3'd2;
   localparam logic [2:0] W_RESP = 3'd3;
   localparam logic [2:0] R_ADDR = 3'd4;
   localparam logic [2:0] R_DATA = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   logic [2:0]             r_state;
   logic [1:0]             r_mode;
   logic [AXI_AWIDTH-1:0]  r_base;
   logic [AXI_AWIDTH-1:0]  r_addr;
   logic [31:0]            r_num;
   logic [31:0]            r_remaining;
   logic [8:0]             r_eff_len;
   logic [WORD_WIDTH-1:0]  r_seed;
   logic [8:0]             r_len;
   logic [8:0]             r_burst_left;
   logic [AXI_DWIDTH-1:0]  r_wdata;
   logic [AXI_DWIDTH-1:0]  r_rexp;
   logic [31:0]            r_err_count;
   logic [31:0]            r_first_err;
   logic [31:0]            r_beats_written;
   logic [31:0]            r_beats_read;
   logic                   r_done;

   logic [12:0]            w_to4k_bytes;
   logic [12:0]            w_to4k_beats;
   logic [8:0]             w_len;
   logic [AXI_AWIDTH-1:0]  w_burst_bytes;
   logic                   w_rd_mismatch;
   logic                   w_exp_last;
   logic [1:0]             w_err_inc;
   logic [32:0]            w_err_sum;
   logic [31:0]            w_err_next;
   logic                   w_unused;

   function automatic logic [AXI_DWIDTH-1:0] f_pattern(input logic [WORD_WIDTH-1:0] s,
                                                      input logic [31:0] beat);
      logic [AXI_DWIDTH-1:0] v;
      logic [WORD_WIDTH-1:0] w0;
      w0 = s + WORD_WIDTH'(beat) * WORD_WIDTH'(WPB);
      v  = '0;
      for (int unsigned k = 0; k < WPB; k++)
         v[k*WORD_WIDTH +: WORD_WIDTH] = w0 + WORD_WIDTH'(k);
      return v;
   endfunction

   // Burst length: min of configured length, beats left, and beats to the next 4KB page.
   always_comb begin
      w_to4k_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
      w_to4k_beats = w_to4k_bytes >> SIZE;
      w_len        = r_eff_len;
      if (r_remaining < 32'(w_len))
         w_len = r_remaining[8:0];
      if (w_to4k_beats < 13'(w_len))
         w_len = w_to4k_beats[8:0];
   end

   assign w_burst_bytes = AXI_AWIDTH'(r_len) << SIZE;
   assign w_rd_mismatch = (m.m_rdata != r_rexp);
   assign w_exp_last    = (r_burst_left == 9'd1);

   always_comb begin
      w_err_inc = '0;
      if (r_state == W_RESP && m.m_bvalid && m.m_bresp != 2'b00)
         w_err_inc = 2'd1;
      if (r_state == R_DATA && m.m_rvalid)
         w_err_inc = 2'(w_rd_mismatch) + 2'(m.m_rresp != 2'b00) + 2'(m.m_rlast != w_exp_last);
      w_err_sum  = {1'b0, r_err_count} + 33'(w_err_inc);
      w_err_next = w_err_sum[32] ? '1 : w_err_sum[31:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_mode          <= '0;
         r_base          <= '0;
         r_addr          <= '0;
         r_num           <= '0;
         r_remaining     <= '0;
         r_eff_len       <= 9'd1;
         r_seed          <= '0;
         r_len           <= '0;
         r_burst_left    <= '0;
         r_wdata         <= '0;
         r_rexp          <= '0;
         r_err_count     <= '0;
         r_first_err     <= '1;
         r_beats_written <= '0;
         r_beats_read    <= '0;
         r_done          <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_err_count <= w_err_next;
         case (r_state)
            IDLE: if (start) begin
               r_mode          <= mode;
               r_base          <= base_addr;
               r_addr          <= base_addr;
               r_num           <= num_beats;
               r_remaining     <= num_beats;
               r_seed          <= WORD_WIDTH'(seed);
               if (burst_len == 9'd0)
                  r_eff_len <= 9'd1;
               else if (burst_len > 9'(AXI_MAX_BURST_LEN))
                  r_eff_len <= 9'(AXI_MAX_BURST_LEN);
               else
                  r_eff_len <= burst_len;
               r_err_count     <= '0;
               r_first_err     <= '1;
               r_beats_written <= '0;
               r_beats_read    <= '0;
               if (num_beats == 32'd0)
                  r_state <= DONE;
               else if (mode == 2'd1)
                  r_state <= R_ADDR;
               else
                  r_state <= W_ADDR;
            end
            W_ADDR: if (m.m_awready) begin
               r_len        <= w_len;
               r_burst_left <= w_len;
               r_wdata      <= f_pattern(r_seed, r_beats_written);
               r_state      <= W_DATA;
            end
            W_DATA: if (m.m_wready) begin
               r_beats_written <= r_beats_written + 32'd1;
               r_remaining     <= r_remaining - 32'd1;
               r_burst_left    <= r_burst_left - 9'd1;
               r_wdata         <= f_pattern(r_seed, r_beats_written + 32'd1);
               if (w_exp_last) begin
                  r_addr  <= r_addr + w_burst_bytes;
                  r_state <= W_RESP;
               end
            end
            W_RESP: if (m.m_bvalid) begin
               if (r_remaining != 32'd0)
                  r_state <= W_ADDR;
               else if (r_mode == 2'd0)
                  r_state <= DONE;
               else begin
                  r_addr      <= r_base;
                  r_remaining <= r_num;
                  r_state     <= R_ADDR;
               end
            end
            R_ADDR: if (m.m_arready) begin
               r_len        <= w_len;
               r_burst_left <= w_len;
               r_rexp       <= f_pattern(r_seed, r_beats_read);
               r_state      <= R_DATA;
            end
            // Burst closes on the expected last beat; a wrong rlast is only counted as an error.
            R_DATA: if (m.m_rvalid) begin
               r_beats_read <= r_beats_read + 32'd1;
               r_remaining  <= r_remaining - 32'd1;
               r_burst_left <= r_burst_left - 9'd1;
               r_rexp       <= f_pattern(r_seed, r_beats_read + 32'd1);
               if (w_rd_mismatch && r_first_err == '1)
                  r_first_err <= r_beats_read;
               if (w_exp_last) begin
                  r_addr  <= r_addr + w_burst_bytes;
                  r_state <= (r_remaining == 32'd1) ? DONE : R_ADDR;
               end
            end
            DONE: begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign m.m_awid    = 4'(AXI_ID);
   assign m.m_awaddr  = r_addr;
   assign m.m_awvalid = (r_state == W_ADDR);
   assign m.m_awlen   = 8'(w_len - 9'd1);
   assign m.m_awsize  = 3'(SIZE);
   assign m.m_awburst = 2'b01;

   assign m.m_wid     = 4'(AXI_ID);
   assign m.m_wdata   = r_wdata;
   assign m.m_wvalid  = (r_state == W_DATA);
   assign m.m_wlast   = w_exp_last;
   assign m.m_wstrb   = '1;

   assign m.m_bready  = (r_state == W_RESP);

   assign m.m_arid    = 4'(AXI_ID);
   assign m.m_araddr  = r_addr;
   assign m.m_arvalid = (r_state == R_ADDR);
   assign m.m_arlen   = 8'(w_len - 9'd1);
   assign m.m_arsize  = 3'(SIZE);
   assign m.m_arburst = 2'b01;

   assign m.m_rready  = (r_state == R_DATA);

   assign busy           = (r_state != IDLE);
   assign done           = r_done;
   assign err_count      = r_err_count;
   assign first_err_beat = r_first_err;
   assign beats_written  = r_beats_written;
   assign beats_read     = r_beats_read;

   assign w_unused = ^{m.m_rid, m.m_bid};
endmodule
